// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard sources from the pipeline stages and the
// stall/bubble controls returned to every pipeline register and the PC.
interface pipe_hazard_ctrl_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_use_rs;
  logic       id_use_rt;
  logic       id_use_hilo;
  logic       id_is_muldiv;
  logic [4:0] ex_rd;
  logic       ex_wen;
  logic       ex_is_load;
  logic       ex_muldiv_start;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       stall_pc;
  logic       stall_ifid;
  logic       stall_idex;
  logic       stall_exmem;
  logic       stall_memwb;
  logic       bubble_ifid;
  logic       bubble_idex;
  logic       bubble_exmem;
  logic       bubble_memwb;
  logic       muldiv_busy;

  modport master (
    input  id_rs, id_rt, id_use_rs, id_use_rt, id_use_hilo, id_is_muldiv,
    input  ex_rd, ex_wen, ex_is_load, ex_muldiv_start, ex_branch_taken,
    input  mem_req, mem_ready,
    output stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
    output bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb,
    output muldiv_busy
  );

  modport slave (
    output id_rs, id_rt, id_use_rs, id_use_rt, id_use_hilo, id_is_muldiv,
    output ex_rd, ex_wen, ex_is_load, ex_muldiv_start, ex_branch_taken,
    output mem_req, mem_ready,
    input  stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
    input  bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb,
    input  muldiv_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline.
// Define PIPE_HAZARD_CTRL_MULDIV_EN to track mul/div occupancy and stall HI/LO users.
module pipe_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W         = $clog2(MULDIV_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 resetn,
  pipe_hazard_ctrl_if.master   hz
);

  logic mem_wait;
  logic load_use;
  logic md_haz;
  logic busy;

  assign mem_wait = hz.mem_req & ~hz.mem_ready;

  assign load_use = hz.ex_is_load & hz.ex_wen & (hz.ex_rd != 5'd0) &
                    ((hz.id_use_rs & (hz.id_rs == hz.ex_rd)) |
                     (hz.id_use_rt & (hz.id_rt == hz.ex_rd)));

`ifdef PIPE_HAZARD_CTRL_MULDIV_EN
  logic [CNT_W-1:0] cnt;

  // Counter keeps running through memory waits; an issue held by a wait does not load it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      cnt <= '0;
    else if (hz.ex_muldiv_start && !mem_wait)
      cnt <= CNT_W'(MULDIV_CYCLES);
    else if (cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign busy   = (cnt != '0);
  assign md_haz = busy & (hz.id_use_hilo | hz.id_is_muldiv);
`else
  logic unused_md;

  assign busy      = 1'b0;
  assign md_haz    = 1'b0;
  assign unused_md = ^{clk, hz.id_use_hilo, hz.id_is_muldiv, hz.ex_muldiv_start};
`endif

  logic s_pc, s_ifid, s_idex, s_exmem, s_memwb;
  logic b_ifid, b_idex, b_exmem, b_memwb;

  // Strict priority: memory wait, then taken branch (ID is wrong-path), then ID hazards.
  always_comb begin
    s_pc    = 1'b0;
    s_ifid  = 1'b0;
    s_idex  = 1'b0;
    s_exmem = 1'b0;
    s_memwb = 1'b0;
    b_ifid  = 1'b0;
    b_idex  = 1'b0;
    b_exmem = 1'b0;
    b_memwb = 1'b0;
    if (!resetn) begin
      b_ifid  = 1'b1;
      b_idex  = 1'b1;
      b_exmem = 1'b1;
      b_memwb = 1'b1;
    end else if (mem_wait) begin
      s_pc    = 1'b1;
      s_ifid  = 1'b1;
      s_idex  = 1'b1;
      s_exmem = 1'b1;
      b_memwb = 1'b1;
    end else if (hz.ex_branch_taken) begin
      b_ifid  = 1'b1;
      b_idex  = 1'b1;
    end else if (load_use || md_haz) begin
      s_pc    = 1'b1;
      s_ifid  = 1'b1;
      b_idex  = 1'b1;
    end
  end

  assign hz.stall_pc     = s_pc;
  assign hz.stall_ifid   = s_ifid;
  assign hz.stall_idex   = s_idex;
  assign hz.stall_exmem  = s_exmem;
  assign hz.stall_memwb  = s_memwb;
  assign hz.bubble_ifid  = b_ifid;
  assign hz.bubble_idex  = b_idex;
  assign hz.bubble_exmem = b_exmem;
  assign hz.bubble_memwb = b_memwb;
  assign hz.muldiv_busy  = busy;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle reference model.
module tb_pipe_hazard_ctrl;

  localparam int MULDIV_CYCLES = 4;
`ifdef PIPE_HAZARD_CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  // Output vector order: stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
  // bubble_ifid, bubble_idex, bubble_exmem, bubble_memwb, muldiv_busy
  localparam logic [9:0] NONE = 10'b00000_0000_0;
  localparam logic [9:0] RST  = 10'b00000_1111_0;
  localparam logic [9:0] LU   = 10'b11000_0100_0;
  localparam logic [9:0] BR   = 10'b00000_1100_0;
  localparam logic [9:0] MW   = 10'b11110_0001_0;
  localparam logic [9:0] BSY  = MD_EN ? 10'b00000_0000_1 : 10'b0;
  localparam logic [9:0] HZ   = MD_EN ? (LU | BSY) : NONE;

  logic clk = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   md_left = 0;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MULDIV_CYCLES(MULDIV_CYCLES)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (bus)
  );

  always #5 clk = ~clk;

  logic [9:0] dut_vec;
  assign dut_vec = {bus.stall_pc, bus.stall_ifid, bus.stall_idex, bus.stall_exmem,
                    bus.stall_memwb, bus.bubble_ifid, bus.bubble_idex, bus.bubble_exmem,
                    bus.bubble_memwb, bus.muldiv_busy};

  // Reference: remaining busy cycles of the mul/div unit.
  always @(posedge clk or negedge resetn) begin
    if (!resetn)
      md_left <= 0;
    else if (MD_EN && bus.ex_muldiv_start && !(bus.mem_req && !bus.mem_ready))
      md_left <= MULDIV_CYCLES;
    else if (md_left > 0)
      md_left <= md_left - 1;
  end

  function automatic logic [9:0] model_vec();
    bit mw, lu, bz, md;
    logic [9:0] b;
    mw = bus.mem_req && !bus.mem_ready;
    lu = bus.ex_is_load && bus.ex_wen && (bus.ex_rd != 5'd0) &&
         ((bus.id_use_rs && bus.id_rs == bus.ex_rd) || (bus.id_use_rt && bus.id_rt == bus.ex_rd));
    bz = MD_EN && (md_left > 0);
    md = bz && (bus.id_use_hilo || bus.id_is_muldiv);
    b  = bz ? 10'b1 : 10'b0;
    if (!resetn)             return RST;
    if (mw)                  return MW | b;
    if (bus.ex_branch_taken) return BR | b;
    if (lu || md)            return LU | b;
    return b;
  endfunction

  always @(negedge clk) begin
    logic [9:0] e;
    e = model_vec();
    checks++;
    if (dut_vec !== e) begin
      errors++;
      $display("FAIL model t=%0t got %b expected %b", $time, dut_vec, e);
    end
  end

  task automatic check_now(input string nm, input logic [9:0] exp);
    checks++;
    if (dut_vec !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", nm, dut_vec, exp);
    end
  endtask

  task automatic tick_chk(input string nm, input logic [9:0] exp);
    @(negedge clk);
    check_now(nm, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_use_rs = 1'b0; bus.id_use_rt = 1'b0;
    bus.id_use_hilo = 1'b0; bus.id_is_muldiv = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_wen = 1'b0; bus.ex_is_load = 1'b0;
    bus.ex_muldiv_start = 1'b0; bus.ex_branch_taken = 1'b0;
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [4:0] rd);
    bus.ex_is_load = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = rd;
    bus.id_rs = rd; bus.id_use_rs = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0;
    clear_in();
    bus.mem_req = 1'b1; bus.ex_branch_taken = 1'b1;
    set_lu(5'd5);
    #2;
    check_now("reset_forced", RST);
    repeat (2) @(posedge clk);
    #1;
    check_now("reset_held", RST);
    clear_in();
    resetn = 1'b1;
    tick_chk("idle", NONE);

    // load-use: exactly one bubble, then the load sits in MEM
    set_lu(5'd5);
    tick_chk("lu_rs", LU);
    clear_in();
    tick_chk("lu_release", NONE);
    bus.ex_is_load = 1'b1; bus.ex_wen = 1'b1; bus.ex_rd = 5'd7;
    bus.id_rt = 5'd7; bus.id_use_rt = 1'b1; bus.id_rs = 5'd7;
    tick_chk("lu_rt", LU);
    bus.id_use_rt = 1'b0;
    tick_chk("lu_unused_src", NONE);
    clear_in();
    set_lu(5'd9); bus.ex_wen = 1'b0;
    tick_chk("lu_no_wen", NONE);
    clear_in();
    set_lu(5'd0);
    tick_chk("lu_rd0", NONE);

    // taken branch overrides load-use
    clear_in();
    set_lu(5'd5); bus.ex_branch_taken = 1'b1;
    tick_chk("branch_over_lu", BR);

    // memory wait with a pending branch: 3 frozen cycles, flush on the 4th
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick_chk("memwait", MW);
    bus.mem_ready = 1'b1;
    tick_chk("memwait_flush", BR);
    clear_in();
    bus.mem_req = 1'b1; bus.mem_ready = 1'b1;
    tick_chk("mem_ready_hit", NONE);

    // mul/div issue then dependent mfhi
    clear_in();
    bus.ex_muldiv_start = 1'b1;
    tick_chk("md_issue", NONE);
    bus.ex_muldiv_start = 1'b0; bus.id_use_hilo = 1'b1;
    for (int i = 0; i < MULDIV_CYCLES; i++) tick_chk("md_busy_hilo", HZ);
    tick_chk("md_release", NONE);

    // issue held by a memory wait does not load; a later issue counts down through waits
    clear_in();
    bus.ex_muldiv_start = 1'b1; bus.mem_req = 1'b1;
    tick_chk("md_issue_in_wait", MW);
    clear_in();
    bus.id_is_muldiv = 1'b1;
    tick_chk("md_no_load", NONE);
    clear_in();
    bus.ex_muldiv_start = 1'b1;
    tick_chk("md_issue2", NONE);
    clear_in();
    bus.mem_req = 1'b1;
    tick_chk("md_wait1", MW | BSY);
    tick_chk("md_wait2", MW | BSY);
    clear_in();
    tick_chk("md_cnt2", BSY);
    bus.id_is_muldiv = 1'b1;
    tick_chk("md_cnt1_muldiv", HZ);
    tick_chk("md_done", NONE);

    // reset pulse mid-countdown
    clear_in();
    bus.ex_muldiv_start = 1'b1;
    tick_chk("rst_issue", NONE);
    bus.ex_muldiv_start = 1'b0; bus.id_use_hilo = 1'b1;
    tick_chk("rst_cnt4", HZ);
    tick_chk("rst_cnt3", HZ);
    #2;
    resetn = 1'b0;
    #1;
    check_now("rst_mid_count", RST);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick_chk("rst_after_release", NONE);
    tick_chk("rst_after_release2", NONE);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
